// File: rtl/risc_v_rf_pkg.sv
// Shared types, defaults and the write-match helper for the multi-port register file.
package risc_v_rf_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  // The write-match helper works on vectors sized for the largest legal
  // configuration (2 write ports, addresses up to 8 bits); callers zero-extend.
  localparam int RF_MAX_WR = 2;
  localparam int RF_MAX_AW = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  typedef struct packed {
    logic       hit;
    logic [0:0] idx;
  } wr_hit_t;

  // Find the highest-index enabled write port whose address equals addr.
  function automatic wr_hit_t wr_hit(
    input logic [RF_MAX_AW-1:0]           addr,
    input logic [RF_MAX_WR-1:0]           en,
    input logic [RF_MAX_WR*RF_MAX_AW-1:0] waddr_vec
  );
    wr_hit_t res;
    res.hit = 1'b0;
    res.idx = 1'b0;
    for (int i = 0; i < RF_MAX_WR; i++) begin
      if (en[i] && (waddr_vec[i*RF_MAX_AW +: RF_MAX_AW] == addr)) begin
        res.hit = 1'b1;
        res.idx = 1'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/risc_v_regfile_mp_rd_port.sv
// One registered read port: address decode, x0 / out-of-range zeroing,
// optional same-cycle write bypass and the output flop.
module rf_read_port
  import risc_v_rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_REGS   = 32,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_run,
  input  logic [ADDR_WIDTH-1:0]        i_raddr,
  input  logic [DATA_WIDTH-1:0]        i_regs [NUM_REGS],
  input  logic [NUM_WR-1:0]            i_wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [RF_MAX_WR-1:0]           w_en_ext;
  logic [RF_MAX_WR*RF_MAX_AW-1:0] w_waddr_ext;
  wr_hit_t                        w_hit;
  logic [DATA_WIDTH-1:0]          w_byp_data;
  logic                           w_in_range;
  logic                           w_is_x0;
  logic [DATA_WIDTH-1:0]          w_rd_nxt;
  logic [DATA_WIDTH-1:0]          r_rdata;

  // Widen the write-port vectors and locate the winning same-cycle write.
  always_comb begin
    w_en_ext    = '0;
    w_waddr_ext = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_en_ext[i] = i_wr_en[i];
      w_waddr_ext[i*RF_MAX_AW +: RF_MAX_AW] = RF_MAX_AW'(i_waddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    w_hit      = wr_hit(RF_MAX_AW'(i_raddr), w_en_ext, w_waddr_ext);
    w_byp_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_byp_data = (w_hit.idx == 1'(i)) ? i_wdata[i*DATA_WIDTH +: DATA_WIDTH] : w_byp_data;
    end
  end

  // Select the next read value; x0, out-of-range and the clear sweep read as zero.
  always_comb begin
    w_in_range = ({1'b0, i_raddr} < LP_NUM_REGS);
    w_is_x0    = (i_raddr == '0);
    w_rd_nxt   = '0;
    if (!i_run || w_is_x0 || !w_in_range) begin
      w_rd_nxt = '0;
    end else if ((BYPASS != 0) && w_hit.hit) begin
      w_rd_nxt = w_byp_data;
    end else begin
      w_rd_nxt = i_regs[i_raddr];
    end
  end

  // Output flop gives the one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd_nxt;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/risc_v_regfile_mp.sv
// Multi-port integer register file with a post-reset clear sweep and ready flag.
module risc_v_regfile_mp
  import risc_v_rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            reg_write,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] write_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] read_data,
  output logic                         ready
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST     = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH:0]   LP_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);

  rf_state_e             r_state;
  rf_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic                  w_run;
  logic [NUM_WR-1:0]     w_wr_valid;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  assign w_run = (r_state == ST_RUN);

  // State, sweep counter and ready flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Sweep through every entry once, then stay in RUN until the next reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_ready_nxt   = r_ready;
    case (r_state)
      ST_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (r_clr_cnt == LP_LAST) begin
          w_state_nxt = ST_RUN;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_CLEAR;
          w_ready_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
        w_ready_nxt   = 1'b0;
      end
    endcase
  end

  // A write counts only in RUN, to a non-zero, in-range address.
  always_comb begin
    w_wr_valid = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_wr_valid[i] = w_run && reg_write[i]
                   && (write_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                   && ({1'b0, write_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} < LP_NUM_REGS);
    end
  end

  // Array update: zero one entry per sweep cycle, otherwise apply writes with
  // the higher-numbered port landing last so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_regs[r_clr_cnt] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (w_wr_valid[i]) begin
            r_regs[write_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= write_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .NUM_WR     (NUM_WR),
        .BYPASS     (BYPASS)
      ) u_rd (
        .clk     (clk),
        .rst     (rst),
        .i_run   (w_run),
        .i_raddr (read_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
        .i_regs  (r_regs),
        .i_wr_en (reg_write),
        .i_waddr (write_addr),
        .i_wdata (write_data),
        .o_rdata (read_data[p*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  assign ready = r_ready;

endmodule

// File: tb/tb_risc_v_regfile_mp.sv
// Self-checking bench: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based reference model.
module tb_risc_v_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  reg_write;
  logic [9:0]  write_addr;
  logic [63:0] write_data;
  logic [9:0]  read_addr;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic        ready_a;
  logic        ready_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  int          m_cnt;
  bit          m_ready;
  logic [31:0] exp_byp [2];
  logic [31:0] exp_nob [2];

  risc_v_regfile_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)
  ) dut_byp (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
    .write_data(write_data), .read_addr(read_addr), .read_data(rd_a), .ready(ready_a)
  );

  risc_v_regfile_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)
  ) dut_nob (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
    .write_data(write_data), .read_addr(read_addr), .read_data(rd_b), .ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, updating the reference model with the inputs seen at that edge.
  task automatic tick();
    for (int p = 0; p < 2; p++) begin
      int ra;
      ra = int'(read_addr[p*5 +: 5]);
      if (rst || !m_ready || ra == 0) begin
        exp_byp[p] = 32'h0;
        exp_nob[p] = 32'h0;
      end else begin
        exp_nob[p] = m_regs[ra];
        exp_byp[p] = m_regs[ra];
        for (int w = 0; w < 2; w++)
          if (reg_write[w] && int'(write_addr[w*5 +: 5]) == ra) exp_byp[p] = write_data[w*32 +: 32];
      end
    end
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) begin
        m_ready = 1'b1;
        foreach (m_regs[i]) m_regs[i] = 32'h0;
      end
    end else begin
      for (int w = 0; w < 2; w++)
        if (reg_write[w] && write_addr[w*5 +: 5] != 5'd0) m_regs[int'(write_addr[w*5 +: 5])] = write_data[w*32 +: 32];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write  = 2'b00;
    write_addr = 10'd0;
    write_data = 64'd0;
    read_addr  = 10'd0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({ready_a, ready_b, rd_a, rd_b} !== 130'd0) begin
      failures++;
      $display("FAIL reset_state got ready=%b%b rd_a=%h rd_b=%h want all zero", ready_a, ready_b, rd_a, rd_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if ({ready_a, ready_b} !== ((i == 31) ? 2'b11 : 2'b00)) begin
        failures++;
        $display("FAIL sweep_ready edge=%0d got=%b%b want=%0d", i + 1, ready_a, ready_b, (i == 31));
      end
    end
    read_addr[4:0] = 5'd5;
    tick();
    checks++;
    if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL x5_after_sweep got a=%h b=%h want 00000000", rd_a[31:0], rd_b[31:0]);
    end
  endtask

  task automatic test_write_read();
    idle();
    reg_write = 2'b01; write_addr[4:0] = 5'd7; write_data[31:0] = 32'hDEADBEEF;
    tick();
    idle();
    read_addr[4:0] = 5'd7;
    tick();
    checks++;
    if (rd_a[31:0] !== 32'hDEADBEEF || rd_b[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_x7 got a=%h b=%h want deadbeef", rd_a[31:0], rd_b[31:0]);
    end
    idle();
    reg_write = 2'b01; write_addr[4:0] = 5'd0; write_data[31:0] = 32'h00001234;
    tick();
    idle();
    tick();
    checks++;
    if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL rd_x0 got a=%h b=%h want 00000000", rd_a[31:0], rd_b[31:0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    reg_write = 2'b01; write_addr[4:0] = 5'd3; write_data[31:0] = 32'hA5A5A5A5;
    read_addr[9:5] = 5'd3;
    tick();
    checks++;
    if (rd_a[63:32] !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass_on got=%h want a5a5a5a5", rd_a[63:32]);
    end
    checks++;
    if (rd_b[63:32] !== 32'h0) begin
      failures++;
      $display("FAIL bypass_off got=%h want 00000000", rd_b[63:32]);
    end
    idle();
    read_addr[9:5] = 5'd3;
    tick();
    checks++;
    if (rd_a[63:32] !== 32'hA5A5A5A5 || rd_b[63:32] !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL x3_after_write got a=%h b=%h want a5a5a5a5", rd_a[63:32], rd_b[63:32]);
    end
  endtask

  task automatic test_dual_write();
    idle();
    reg_write = 2'b11;
    write_addr = {5'd9, 5'd9};
    write_data = {32'h22222222, 32'h11111111};
    tick();
    idle();
    read_addr[4:0] = 5'd9;
    tick();
    checks++;
    if (rd_a[31:0] !== 32'h22222222 || rd_b[31:0] !== 32'h22222222) begin
      failures++;
      $display("FAIL dual_write_x9 got a=%h b=%h want 22222222", rd_a[31:0], rd_b[31:0]);
    end
    idle();
    reg_write = 2'b11;
    write_addr = {5'd12, 5'd12};
    write_data = {32'h44444444, 32'h33333333};
    read_addr[9:5] = 5'd12;
    tick();
    checks++;
    if (rd_a[63:32] !== 32'h44444444 || rd_b[63:32] !== 32'h0) begin
      failures++;
      $display("FAIL dual_bypass_x12 got a=%h b=%h want 44444444/00000000", rd_a[63:32], rd_b[63:32]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reg_write = 2'($urandom_range(0, 3));
      for (int w = 0; w < 2; w++) begin
        write_addr[w*5 +: 5] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
        write_data[w*32 +: 32] = $urandom;
      end
      for (int p = 0; p < 2; p++)
        read_addr[p*5 +: 5] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd_a[p*32 +: 32] !== exp_byp[p]) begin
          failures++;
          $display("FAIL rand_bypass cyc=%0d port=%0d got=%h want=%h", c, p, rd_a[p*32 +: 32], exp_byp[p]);
        end
        checks++;
        if (rd_b[p*32 +: 32] !== exp_nob[p]) begin
          failures++;
          $display("FAIL rand_nobypass cyc=%0d port=%0d got=%h want=%h", c, p, rd_b[p*32 +: 32], exp_nob[p]);
        end
      end
      checks++;
      if ({ready_a, ready_b} !== 2'b11) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b%b want 11", c, ready_a, ready_b);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({ready_a, ready_b} !== 2'b00) begin
        failures++;
        $display("FAIL partial_sweep_ready edge=%0d got=%b%b want 00", i + 1, ready_a, ready_b);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reg_write = 2'b01; write_addr[4:0] = 5'd4; write_data[31:0] = 32'h0000FFFF;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if ({ready_a, ready_b} !== ((i == 31) ? 2'b11 : 2'b00)) begin
        failures++;
        $display("FAIL resweep_ready edge=%0d got=%b%b want=%0d", i + 1, ready_a, ready_b, (i == 31));
      end
    end
    idle();
    read_addr[4:0] = 5'd4;
    tick();
    checks++;
    if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL x4_sweep_write got a=%h b=%h want 00000000", rd_a[31:0], rd_b[31:0]);
    end
  endtask

  task automatic test_reset_in_run();
    idle();
    reg_write = 2'b01; write_addr[4:0] = 5'd7; write_data[31:0] = 32'hDEADBEEF;
    tick();
    idle();
    read_addr = {5'd7, 5'd7};
    tick();
    checks++;
    if (rd_a !== {2{32'hDEADBEEF}} || rd_b !== {2{32'hDEADBEEF}}) begin
      failures++;
      $display("FAIL run_x7_pre got a=%h b=%h want deadbeef", rd_a, rd_b);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ready_a, ready_b, rd_a, rd_b} !== 130'd0) begin
      failures++;
      $display("FAIL run_reset got ready=%b%b a=%h b=%h want all zero", ready_a, ready_b, rd_a, rd_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (rd_a !== 64'd0 || rd_b !== 64'd0) begin
        failures++;
        $display("FAIL sweep_rd_zero edge=%0d got a=%h b=%h want 0", i + 1, rd_a, rd_b);
      end
    end
    tick();
    checks++;
    if ({ready_a, ready_b} !== 2'b11 || rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL x7_after_resweep got ready=%b%b a=%h b=%h want 11/00000000", ready_a, ready_b, rd_a[31:0], rd_b[31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    m_cnt   = 0;
    m_ready = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_write();
    test_random();
    test_reset_mid_sweep();
    test_reset_in_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
